// File: rtl/mem_if_pkg.sv
// mem_if_pkg: definitions shared by the main memory block and the data cache.
//   MEM_ADDR_WIDTH  : default byte address width
//   MEM_BLOCK_BYTES : default bytes per cache/memory block
//   OFFSET_BITS     : byte-offset bits within a default-sized block
//   state_t         : request handshake state (S_IDLE / S_BUSY)
package mem_if_pkg;

  localparam int MEM_ADDR_WIDTH  = 16;
  localparam int MEM_BLOCK_BYTES = 32;
  localparam int OFFSET_BITS     = $clog2(MEM_BLOCK_BYTES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_block_array.sv
// mem_block_array: single-port block storage, DEPTH x WIDTH.
//   clk    : clock (rising edge)
//   rst_n  : async active-low reset, clears the read register only
//   we     : write enable, commits wdata to mem[addr]
//   re     : read enable, loads rdata from mem[addr]
//   addr   : block index
//   wdata  : write data
//   rdata  : registered read data, holds until the next read
// Storage itself is never reset so contents persist across reset.
module mem_block_array #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_array [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem_array[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/main_memory_block.sv
// main_memory_block: fixed-latency backing store serving whole blocks to
// the data cache.
//   clk, rst_n       : clock and async active-low reset
//   mem_addr_block   : block byte address (offset bits ignored)
//   mem_wdata_block  : write-back block data
//   mem_read/write   : one-cycle request pulses
//   mem_rdata_block  : registered read data, holds until the next read
//   mem_ready        : one-cycle completion pulse, LATENCY cycles after accept
//   mem_busy         : high from cycle after accept through the ready cycle
//   mem_err          : sticky protocol error (request while busy, or both)
//   rd_count/wr_count: accepted request counters
// Optional feature: define MEM_STATS_EN to build saturating request
// counters; otherwise rd_count/wr_count are constant zero.
module main_memory_block
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int BLOCK_BYTES = MEM_BLOCK_BYTES,
  parameter int MEM_BLOCKS  = 2048,
  parameter int LATENCY     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    mem_addr_block,
  input  logic [BLOCK_BYTES*8-1:0] mem_wdata_block,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic [BLOCK_BYTES*8-1:0] mem_rdata_block,
  output logic                     mem_ready,
  output logic                     mem_busy,
  output logic                     mem_err,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count
);

  localparam int OFF_W = (BLOCK_BYTES == MEM_BLOCK_BYTES) ? OFFSET_BITS
                                                          : $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(MEM_BLOCKS);

  state_t                   state_reg, state_next;
  logic [7:0]               cnt_reg, cnt_next;
  logic                     op_wr_reg, op_wr_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [BLOCK_BYTES*8-1:0] wdata_reg, wdata_next;
  logic                     ready_reg, ready_next;
  logic                     busy_reg, busy_next;
  logic                     err_reg, err_next;
  logic                     accept;
  logic                     done;

  // Offset bits and any index bits above MEM_BLOCKS are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^mem_addr_block;

  assign accept = (state_reg == S_IDLE) && (mem_read ^ mem_write);
  // Countdown reaches zero on the edge that must raise mem_ready.
  assign done   = (state_reg == S_BUSY) && (cnt_reg == 8'd0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_wr_next = op_wr_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    ready_next = 1'b0;
    busy_next  = busy_reg;
    err_next   = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_BUSY;
          cnt_next   = 8'(LATENCY - 1);
          op_wr_next = mem_write;
          idx_next   = mem_addr_block[OFF_W +: IDX_W];
          wdata_next = mem_wdata_block;
        end else if (mem_read && mem_write) begin
          err_next = 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_read || mem_write) begin
          err_next = 1'b1;
        end
        if (done) begin
          state_next = S_IDLE;
          ready_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // busy spans the ready cycle itself, so it drops one edge after ready.
    if (accept) begin
      busy_next = 1'b1;
    end else if (ready_reg) begin
      busy_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      op_wr_reg <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_wr_reg <= op_wr_next;
      idx_reg   <= idx_next;
      wdata_reg <= wdata_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  // Array access happens on the completion edge, so a read issued after a
  // finished write to the same block always observes the new contents.
  mem_block_array #(
    .DEPTH(MEM_BLOCKS),
    .WIDTH(BLOCK_BYTES * 8)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (done && op_wr_reg),
    .re   (done && !op_wr_reg),
    .addr (idx_reg),
    .wdata(wdata_reg),
    .rdata(mem_rdata_block)
  );

  assign mem_ready = ready_reg;
  assign mem_busy  = busy_reg;
  assign mem_err   = err_reg;

`ifdef MEM_STATS_EN
  logic [15:0] rd_count_reg;
  logic [15:0] wr_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else if (accept) begin
      if (mem_read && (rd_count_reg != 16'hFFFF)) begin
        rd_count_reg <= rd_count_reg + 16'd1;
      end
      if (mem_write && (wr_count_reg != 16'hFFFF)) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule
